// File: rtl/rgb_white_balance.sv
// ---------------------------------------------------------------------------
// rgb_white_balance
//
// Purpose:
//   Applies per-channel white-balance gains to a packed RGB AXI-Stream.
//   Each component is scaled by an unsigned fixed-point gain (unity is
//   2^FRAC_BITS). The result is rounded half-up and saturated to the
//   component range. A bypass setting passes pixels through unchanged
//   with the same latency. New gain/bypass settings are held pending
//   and only take effect on the first beat of a frame (tuser = 1), so a
//   frame is never processed with mixed settings.
//
// Pipeline (all stages advance together on en = !wb_tvalid_o | wb_tready_i):
//   p0 : input register (pixel, sideband, per-beat gain/bypass snapshot)
//   p1 : full-precision multiply
//   p2 : round / saturate / bypass select, drives the output stream
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   gain_r_i/gain_g_i/gain_b_i   requested channel gains (GAIN_WIDTH)
//   bypass_i                     requested bypass
//   gain_update_i                strobe capturing requested settings
//   gain_pending_o               captured settings not yet applied
//   rgb_t*                       input stream (tuser = SOF, tlast = EOL)
//   wb_t*                        output stream
// Packing: R = [3P-1:2P], G = [2P-1:P], B = [P-1:0]; upper output bits 0.
// ---------------------------------------------------------------------------
module rgb_white_balance #(
  parameter int PX_WIDTH    = 10,
  parameter int TDATA_WIDTH = 32,
  parameter int GAIN_WIDTH  = 12,
  parameter int FRAC_BITS   = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [GAIN_WIDTH-1:0]  gain_r_i,
  input  logic [GAIN_WIDTH-1:0]  gain_g_i,
  input  logic [GAIN_WIDTH-1:0]  gain_b_i,
  input  logic                   gain_update_i,
  input  logic                   bypass_i,
  output logic                   gain_pending_o,
  input  logic [TDATA_WIDTH-1:0] rgb_tdata_i,
  input  logic                   rgb_tvalid_i,
  input  logic                   rgb_tlast_i,
  input  logic                   rgb_tuser_i,
  output logic                   rgb_tready_o,
  output logic [TDATA_WIDTH-1:0] wb_tdata_o,
  output logic                   wb_tvalid_o,
  output logic                   wb_tlast_o,
  output logic                   wb_tuser_o,
  input  logic                   wb_tready_i
);

  localparam int PIX_W  = 3 * PX_WIDTH;
  localparam int PROD_W = PX_WIDTH + GAIN_WIDTH;

  localparam logic [GAIN_WIDTH-1:0] UNITY = GAIN_WIDTH'(1) << FRAC_BITS;
  localparam logic [PROD_W:0]       HALF  = (PROD_W + 1)'(1) << (FRAC_BITS - 1);
  localparam logic [PROD_W:0]       MAXV  = (PROD_W + 1)'({PX_WIDTH{1'b1}});

  // Round half-up, drop the fraction, clamp to the component range.
  // One extra bit on the sum keeps the rounding add from wrapping.
  function automatic logic [PX_WIDTH-1:0] round_sat(input logic [PROD_W-1:0] prod);
    logic [PROD_W:0] sum;
    logic [PROD_W:0] shr;
    sum = {1'b0, prod} + HALF;
    shr = sum >> FRAC_BITS;
    if (shr > MAXV) begin
      return {PX_WIDTH{1'b1}};
    end
    return shr[PX_WIDTH-1:0];
  endfunction

  // Settings: pending (captured by strobe) and active (used by beats)
  logic [GAIN_WIDTH-1:0] r_pend_r, r_pend_g, r_pend_b;
  logic                  r_pend_byp;
  logic                  r_pending;
  logic [GAIN_WIDTH-1:0] r_act_r, r_act_g, r_act_b;
  logic                  r_act_byp;

  logic w_en;
  logic w_accept;
  logic w_apply;

  // Settings seen by the beat being accepted this cycle: an SOF beat that
  // triggers the switch already uses the pending values.
  logic [GAIN_WIDTH-1:0] w_sel_r, w_sel_g, w_sel_b;
  logic                  w_sel_byp;

  assign w_en         = !wb_tvalid_o || wb_tready_i;
  assign rgb_tready_o = w_en;
  assign w_accept     = rgb_tvalid_i && w_en;
  assign w_apply      = w_accept && rgb_tuser_i && r_pending;

  assign w_sel_r   = w_apply ? r_pend_r   : r_act_r;
  assign w_sel_g   = w_apply ? r_pend_g   : r_act_g;
  assign w_sel_b   = w_apply ? r_pend_b   : r_act_b;
  assign w_sel_byp = w_apply ? r_pend_byp : r_act_byp;

  assign gain_pending_o = r_pending;

  // A strobe coinciding with the applying SOF beat loads fresh pending
  // values while the old pending values move to active.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pend_r   <= UNITY;
      r_pend_g   <= UNITY;
      r_pend_b   <= UNITY;
      r_pend_byp <= 1'b0;
      r_pending  <= 1'b0;
      r_act_r    <= UNITY;
      r_act_g    <= UNITY;
      r_act_b    <= UNITY;
      r_act_byp  <= 1'b0;
    end else begin
      if (w_apply) begin
        r_act_r   <= r_pend_r;
        r_act_g   <= r_pend_g;
        r_act_b   <= r_pend_b;
        r_act_byp <= r_pend_byp;
      end
      if (gain_update_i) begin
        r_pend_r   <= gain_r_i;
        r_pend_g   <= gain_g_i;
        r_pend_b   <= gain_b_i;
        r_pend_byp <= bypass_i;
        r_pending  <= 1'b1;
      end else if (w_apply) begin
        r_pending <= 1'b0;
      end
    end
  end

  logic r_vld_p0, r_vld_p1, r_vld_p2;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_vld_p0 <= 1'b0;
      r_vld_p1 <= 1'b0;
      r_vld_p2 <= 1'b0;
    end else if (w_en) begin
      r_vld_p0 <= rgb_tvalid_i;
      r_vld_p1 <= r_vld_p0;
      r_vld_p2 <= r_vld_p1;
    end
  end

  // ---- stage p0: input register ----
  logic [PIX_W-1:0]      r_px_p0;
  logic                  r_last_p0, r_user_p0, r_byp_p0;
  logic [GAIN_WIDTH-1:0] r_gain_r_p0, r_gain_g_p0, r_gain_b_p0;

  always_ff @(posedge clk_i) begin
    if (w_en) begin
      r_px_p0     <= rgb_tdata_i[PIX_W-1:0];
      r_last_p0   <= rgb_tlast_i;
      r_user_p0   <= rgb_tuser_i;
      r_byp_p0    <= w_sel_byp;
      r_gain_r_p0 <= w_sel_r;
      r_gain_g_p0 <= w_sel_g;
      r_gain_b_p0 <= w_sel_b;
    end
  end

  // ---- stage p1: full-precision multiply ----
  logic [PROD_W-1:0] w_prod_r, w_prod_g, w_prod_b;

  assign w_prod_r = PROD_W'(r_px_p0[3*PX_WIDTH-1:2*PX_WIDTH]) * PROD_W'(r_gain_r_p0);
  assign w_prod_g = PROD_W'(r_px_p0[2*PX_WIDTH-1:PX_WIDTH])   * PROD_W'(r_gain_g_p0);
  assign w_prod_b = PROD_W'(r_px_p0[PX_WIDTH-1:0])            * PROD_W'(r_gain_b_p0);

  logic [PROD_W-1:0] r_prod_r_p1, r_prod_g_p1, r_prod_b_p1;
  logic [PIX_W-1:0]  r_px_p1;
  logic              r_last_p1, r_user_p1, r_byp_p1;

  always_ff @(posedge clk_i) begin
    if (w_en) begin
      r_prod_r_p1 <= w_prod_r;
      r_prod_g_p1 <= w_prod_g;
      r_prod_b_p1 <= w_prod_b;
      r_px_p1     <= r_px_p0;
      r_last_p1   <= r_last_p0;
      r_user_p1   <= r_user_p0;
      r_byp_p1    <= r_byp_p0;
    end
  end

  // ---- stage p2: round / saturate / bypass select ----
  logic [PIX_W-1:0] r_pix_p2;
  logic             r_last_p2, r_user_p2;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pix_p2  <= '0;
      r_last_p2 <= 1'b0;
      r_user_p2 <= 1'b0;
    end else if (w_en) begin
      r_pix_p2  <= r_byp_p1 ? r_px_p1
                            : {round_sat(r_prod_r_p1), round_sat(r_prod_g_p1),
                               round_sat(r_prod_b_p1)};
      r_last_p2 <= r_last_p1;
      r_user_p2 <= r_user_p1;
    end
  end

  logic [TDATA_WIDTH-1:0] w_tdata;

  always_comb begin
    w_tdata            = '0;
    w_tdata[PIX_W-1:0] = r_pix_p2;
  end

  assign wb_tdata_o  = w_tdata;
  assign wb_tvalid_o = r_vld_p2;
  assign wb_tlast_o  = r_last_p2;
  assign wb_tuser_o  = r_user_p2;

  // Input bits above the packed pixel carry nothing.
  generate
    if (TDATA_WIDTH > PIX_W) begin : g_pad
      logic w_unused_tdata;
      assign w_unused_tdata = ^rgb_tdata_i[TDATA_WIDTH-1:PIX_W];
    end
  endgenerate

endmodule

// File: tb/tb_rgb_white_balance.sv
// ---------------------------------------------------------------------------
// tb_rgb_white_balance
//
// Scoreboard bench for rgb_white_balance. The driver issues beats and
// gain strobes, keeps a frame-level model of pending/active settings and
// pushes the arithmetically expected output beat for each accepted input.
// A separate monitor drives wb_tready_i (always, random or never) and pops
// and compares each delivered beat, also checking stability while stalled.
// ---------------------------------------------------------------------------
module tb_rgb_white_balance;

  localparam int PXW = 10;
  localparam int TDW = 32;
  localparam int GW  = 12;
  localparam int FB  = 8;
  localparam int MAXPX = (1 << PXW) - 1;

  logic           clk = 1'b0;
  logic           rst_i;
  logic [GW-1:0]  gain_r_i, gain_g_i, gain_b_i;
  logic           gain_update_i, bypass_i, gain_pending_o;
  logic [TDW-1:0] rgb_tdata_i;
  logic           rgb_tvalid_i, rgb_tlast_i, rgb_tuser_i, rgb_tready_o;
  logic [TDW-1:0] wb_tdata_o;
  logic           wb_tvalid_o, wb_tlast_o, wb_tuser_o, wb_tready_i;

  always #5 clk = ~clk;

  rgb_white_balance #(
    .PX_WIDTH(PXW), .TDATA_WIDTH(TDW), .GAIN_WIDTH(GW), .FRAC_BITS(FB)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .gain_r_i(gain_r_i), .gain_g_i(gain_g_i), .gain_b_i(gain_b_i),
    .gain_update_i(gain_update_i), .bypass_i(bypass_i),
    .gain_pending_o(gain_pending_o),
    .rgb_tdata_i(rgb_tdata_i), .rgb_tvalid_i(rgb_tvalid_i),
    .rgb_tlast_i(rgb_tlast_i), .rgb_tuser_i(rgb_tuser_i),
    .rgb_tready_o(rgb_tready_o),
    .wb_tdata_o(wb_tdata_o), .wb_tvalid_o(wb_tvalid_o),
    .wb_tlast_o(wb_tlast_o), .wb_tuser_o(wb_tuser_o),
    .wb_tready_i(wb_tready_i)
  );

  typedef struct {
    logic [TDW-1:0] data;
    logic           last;
    logic           user;
    int             acc_cyc;
    bit             chk_lat;
  } exp_t;

  exp_t sb[$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int rdy_mode = 0;   // 0: ready high, 1: random, 2: ready low

  always @(posedge clk) cyc <= cyc + 1;

  // Settings model: what the frame-level rules say is active / pending.
  int m_act[3];
  int m_pend[3];
  bit m_act_byp, m_pend_byp, m_pending;

  task automatic model_reset();
    m_act      = '{256, 256, 256};
    m_pend     = '{256, 256, 256};
    m_act_byp  = 1'b0;
    m_pend_byp = 1'b0;
    m_pending  = 1'b0;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [PXW-1:0] ref_ch(input int px, input int g, input bit byp);
    longint v;
    if (byp) return PXW'(px);
    v = (longint'(px) * longint'(g) + longint'(1 << (FB - 1))) >> FB;
    if (v > MAXPX) v = MAXPX;
    return PXW'(v);
  endfunction

  // One driver cycle: drive at negedge, observe handshake mid-cycle.
  task automatic step(input bit vld, input int r, input int g, input int b,
                      input bit user, input bit last, input bit upd,
                      input int gr, input int gg, input int gb, input bit byp,
                      output bit acc);
    exp_t e;
    @(negedge clk);
    rgb_tvalid_i = vld;
    rgb_tdata_i  = '0;
    rgb_tdata_i[3*PXW-1:0] = {PXW'(r), PXW'(g), PXW'(b)};
    rgb_tuser_i  = user;
    rgb_tlast_i  = last;
    gain_update_i = upd;
    gain_r_i = GW'(gr);
    gain_g_i = GW'(gg);
    gain_b_i = GW'(gb);
    bypass_i = byp;
    #1;
    chk("gain_pending", gain_pending_o, m_pending);
    acc = vld && rgb_tready_o;
    if (acc) begin
      if (user && m_pending) begin
        m_act     = m_pend;
        m_act_byp = m_pend_byp;
        m_pending = 1'b0;
      end
      e.data = '0;
      e.data[3*PXW-1:0] = {ref_ch(r, m_act[0], m_act_byp),
                           ref_ch(g, m_act[1], m_act_byp),
                           ref_ch(b, m_act[2], m_act_byp)};
      e.last    = last;
      e.user    = user;
      e.acc_cyc = cyc;
      e.chk_lat = (rdy_mode == 0);
      sb.push_back(e);
    end
    if (upd) begin
      m_pend     = '{gr, gg, gb};
      m_pend_byp = byp;
      m_pending  = 1'b1;
    end
  endtask

  task automatic send(input int r, input int g, input int b, input bit user,
                      input bit last, input bit upd, input int gr, input int gg,
                      input int gb, input bit byp);
    bit acc;
    int n;
    step(1'b1, r, g, b, user, last, upd, gr, gg, gb, byp, acc);
    n = 0;
    while (!acc && n < 1000) begin
      step(1'b1, r, g, b, user, last, 1'b0, 0, 0, 0, 1'b0, acc);
      n++;
    end
    if (!acc) chk("input_accept_timeout", {63'd0, acc}, 64'd1);
  endtask

  task automatic beat(input int r, input int g, input int b, input bit user, input bit last);
    send(r, g, b, user, last, 1'b0, 0, 0, 0, 1'b0);
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) step(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0, acc);
  endtask

  task automatic strobe(input int gr, input int gg, input int gb, input bit byp);
    bit acc;
    step(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b1, gr, gg, gb, byp, acc);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 5000) begin
      idle(1);
      k++;
    end
    chk("drain_outstanding", sb.size(), 0);
  endtask

  // Monitor: drives ready, pops/compares delivered beats, checks stalls.
  initial begin : monitor
    logic [TDW-1:0] sd;
    logic sl, su;
    bit held;
    exp_t e;
    held = 1'b0;
    sd = '0; sl = 1'b0; su = 1'b0;
    wb_tready_i = 1'b1;
    forever begin
      @(negedge clk);
      case (rdy_mode)
        0:       wb_tready_i = 1'b1;
        1:       wb_tready_i = ($urandom_range(0, 1) == 1);
        default: wb_tready_i = 1'b0;
      endcase
      #2;
      if (rst_i) begin
        held = 1'b0;
      end else begin
        if (held) begin
          chk("stall_hold", {wb_tvalid_o, wb_tlast_o, wb_tuser_o, wb_tdata_o},
              {1'b1, sl, su, sd});
          held = 1'b0;
        end
        if (wb_tvalid_o && wb_tready_i) begin
          if (sb.size() == 0) begin
            chk("output_without_expected_beat", sb.size(), 1);
          end else begin
            e = sb.pop_front();
            chk("tdata", wb_tdata_o, e.data);
            chk("tlast", wb_tlast_o, e.last);
            chk("tuser", wb_tuser_o, e.user);
            if (e.chk_lat) chk("latency", cyc - e.acc_cyc, 3);
          end
        end else if (wb_tvalid_o) begin
          held = 1'b1;
          sd = wb_tdata_o;
          sl = wb_tlast_o;
          su = wb_tuser_o;
        end
      end
    end
  end

  initial begin : driver
    int gr, gg, gb;
    rst_i = 1'b1;
    rgb_tvalid_i = 1'b0; rgb_tdata_i = '0; rgb_tlast_i = 1'b0; rgb_tuser_i = 1'b0;
    gain_update_i = 1'b0; bypass_i = 1'b0;
    gain_r_i = '0; gain_g_i = '0; gain_b_i = '0;
    model_reset();
    repeat (4) @(negedge clk);
    rst_i = 1'b0;
    #1;
    chk("reset_tvalid", wb_tvalid_o, 0);
    chk("reset_tdata", wb_tdata_o, 0);
    chk("reset_tlast", wb_tlast_o, 0);
    chk("reset_tuser", wb_tuser_o, 0);
    chk("reset_pending", gain_pending_o, 0);
    chk("reset_tready", rgb_tready_o, 1);

    // Unity gains after reset
    beat(1000, 512, 3, 1'b1, 1'b0);
    beat(1000, 512, 3, 1'b0, 1'b0);
    beat(7, 8, 9, 1'b0, 1'b1);
    drain();

    // Gains 1.5 / 0.75 / 1.0 applied at SOF
    strobe(12'h180, 12'h0C0, 12'h100, 1'b0);
    beat(1000, 3, 100, 1'b1, 1'b0);
    beat(100, 100, 100, 1'b0, 1'b1);
    drain();

    // Strobe mid-frame: rest of frame keeps old gains, next SOF switches
    beat(200, 300, 400, 1'b1, 1'b0);
    beat(201, 301, 401, 1'b0, 1'b0);
    send(202, 302, 402, 1'b0, 1'b0, 1'b1, 512, 256, 128, 1'b0);
    beat(203, 303, 403, 1'b0, 1'b0);
    beat(204, 304, 404, 1'b0, 1'b1);
    beat(205, 305, 405, 1'b1, 1'b0);
    beat(206, 306, 406, 1'b0, 1'b1);
    // Strobe coinciding with SOF: older pending applies, new stays pending
    strobe(300, 300, 300, 1'b0);
    send(500, 600, 700, 1'b1, 1'b0, 1'b1, 200, 200, 200, 1'b0);
    beat(510, 610, 710, 1'b0, 1'b1);
    beat(520, 620, 720, 1'b1, 1'b1);
    drain();

    // Bypass with zero gains
    strobe(0, 0, 0, 1'b1);
    for (int i = 0; i < 6; i++)
      beat($urandom_range(0, MAXPX), $urandom_range(0, MAXPX), $urandom_range(0, MAXPX),
           i == 0, i == 5);
    strobe(256, 256, 256, 1'b0);
    beat(1023, 0, 511, 1'b1, 1'b1);
    drain();

    // 1920x4 frame under random output stalls and input gaps
    rdy_mode = 1;
    for (int line = 0; line < 4; line++) begin
      for (int x = 0; x < 1920; x++) begin
        if ($urandom_range(0, 7) == 0) idle(1);
        gr = $urandom_range(0, 4095);
        gg = $urandom_range(0, 1023);
        gb = $urandom_range(128, 512);
        send($urandom_range(0, MAXPX), $urandom_range(0, MAXPX), $urandom_range(0, MAXPX),
             (line == 0) && (x == 0), x == 1919, (x == 960) && (line != 2),
             gr, gg, gb, (line == 3));
      end
    end
    for (int x = 0; x < 40; x++)
      beat($urandom_range(0, MAXPX), $urandom_range(0, MAXPX), $urandom_range(0, MAXPX),
           x == 0, x == 39);
    drain();
    rdy_mode = 0;
    idle(2);

    // Reset with three beats in flight
    rdy_mode = 2;
    idle(1);
    beat(11, 22, 33, 1'b1, 1'b0);
    beat(44, 55, 66, 1'b0, 1'b0);
    beat(77, 88, 99, 1'b0, 1'b1);
    @(negedge clk);
    rst_i = 1'b1;
    rgb_tvalid_i = 1'b0;
    gain_update_i = 1'b0;
    @(negedge clk);
    rst_i = 1'b0;
    #1;
    chk("rst_flush_tvalid", wb_tvalid_o, 0);
    chk("rst_flush_tdata", wb_tdata_o, 0);
    chk("rst_flush_tready", rgb_tready_o, 1);
    chk("rst_flush_pending", gain_pending_o, 0);
    model_reset();
    sb.delete();
    rdy_mode = 0;
    for (int i = 0; i < 8; i++) begin
      idle(1);
      chk("post_reset_no_output", wb_tvalid_o, 0);
    end
    beat(100, 200, 300, 1'b1, 1'b1);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
